// File: rtl/qbus_slave_if_pkg.sv
// qbus_slave_if_pkg
//   Shared constants and types for the QBUS slave-cycle front end:
//   DAL/data widths, the slave FSM state encoding and the byte-enable
//   decode used for DATO/DATOB data phases.
package qbus_slave_if_pkg;

  localparam int DAL_W    = 22;  // full QBUS DAL width
  localparam int DATA_W   = 16;  // register data width
  localparam int IOPAGE_W = 13;  // I/O-page offset bits

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DIR,
    ST_RD_REQ,
    ST_RD_DRIVE,
    ST_RD_REPLY,
    ST_WR_REQ,
    ST_WR_REPLY,
    ST_WAIT_SYNC
  } qbus_state_e;

  // WTBT low in the data phase means a full-word DATO; high means DATOB,
  // where the byte lane follows the address LSB.
  function automatic logic [1:0] write_be(input logic wtbt, input logic odd);
    if (!wtbt) return 2'b11;
    return odd ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/qbus_slave_if_sync.sv
// qbus_slave_if_sync
//   N-bit two-flop synchroniser for raw QBUS receiver lines.
// Ports:
//   clk20  in   clock
//   reset  in   asynchronous active-high reset
//   d      in   N raw asynchronous inputs
//   q      out  N synchronised levels (second flop)
//   rise   out  N one-cycle pulses when the first flop goes 0->1
module qbus_slave_if_sync #(
  parameter int N = 1
) (
  input  logic         clk20,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi]    = sync_reg;
      // Early edge marker, one cycle ahead of the synchronised level.
      assign rise[gi] = meta_reg & ~sync_reg;
    end
  endgenerate

endmodule

// File: rtl/qbus_slave_if.sv
// qbus_slave_if
//   QBUS slave-cycle front end. Latches and decodes the address phase,
//   turns DATI/DATO/DATOB/DATIO cycles into a register read/write
//   handshake and sequences DALtx/DALst/DALbe_L/TRPLY.
// Ports:
//   clk20, reset                    clock, async active-high reset
//   RSYNC/RDIN/RDOUT/RINIT          raw bus receivers (unsynchronised)
//   ZDAL, ZBS7, ZWTBT               DAL/BS7/WTBT from the Am2908s
//   dal_out, DALtx, DALst, DALbe_L  read data and DAL buffer controls
//   TRPLY                           bus reply
//   reg_rd/reg_wr/reg_addr/reg_wdata/reg_be/reg_rdata/reg_ack
//                                   register-block handshake
//   busy                            FSM not idle
module qbus_slave_if
  import qbus_slave_if_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR = 13'o17570,
  parameter int          REG_BITS  = 2,
  parameter int          SETTLE    = 1,
  parameter int          TIMEOUT   = 200
) (
  input  logic                clk20,
  input  logic                reset,
  input  logic                RSYNC,
  input  logic                RDIN,
  input  logic                RDOUT,
  input  logic                RINIT,
  input  logic [DAL_W-1:0]    ZDAL,
  input  logic                ZBS7,
  input  logic                ZWTBT,
  output logic [DAL_W-1:0]    dal_out,
  output logic                DALtx,
  output logic                DALst,
  output logic                DALbe_L,
  output logic                TRPLY,
  output logic                reg_rd,
  output logic                reg_wr,
  output logic [REG_BITS-1:0] reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [1:0]          reg_be,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_ack,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + SETTLE + 1);

  // ---- receiver synchronisation ----
  logic [3:0] bus_sync;
  logic [3:0] bus_rise;

  qbus_slave_if_sync #(.N(4)) u_sync (
    .clk20 (clk20),
    .reset (reset),
    .d     ({RINIT, RDOUT, RDIN, RSYNC}),
    .q     (bus_sync),
    .rise  (bus_rise)
  );

  logic rsync_s, rdin_s, rdout_s, rinit_s;
  assign {rinit_s, rdout_s, rdin_s, rsync_s} = bus_sync;

  // ---- address phase capture ----
  logic [DATA_W-1:0]   zdal_reg;
  logic                zbs7_reg, zwtbt_reg;
  logic [IOPAGE_W-1:0] addr_reg;
  logic                bs7_reg, wr_cycle_reg;

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      zdal_reg     <= '0;
      zbs7_reg     <= 1'b0;
      zwtbt_reg    <= 1'b0;
      addr_reg     <= '0;
      bs7_reg      <= 1'b0;
      wr_cycle_reg <= 1'b0;
    end else begin
      zdal_reg  <= ZDAL[DATA_W-1:0];
      zbs7_reg  <= ZBS7;
      zwtbt_reg <= ZWTBT;
      // The rise pulse coincides with the DAL sample taken on the same
      // edge RSYNC was first seen, so the address is still valid here.
      if (bus_rise[0]) begin
        addr_reg     <= zdal_reg[IOPAGE_W-1:0];
        bs7_reg      <= zbs7_reg;
        wr_cycle_reg <= zwtbt_reg;
      end
    end
  end

  logic hit;
  assign hit = bs7_reg &&
               (addr_reg[IOPAGE_W-1:REG_BITS+1] == BASE_ADDR[IOPAGE_W-1:REG_BITS+1]);
  assign reg_addr = addr_reg[REG_BITS:1];

  // Address lines above the word data and the captured cycle-type bit are
  // not needed by the handshake; wr_cycle is kept for debug visibility.
  logic unused_ok;
  assign unused_ok = &{1'b0, ZDAL[DAL_W-1:DATA_W], wr_cycle_reg, bus_rise[3:1]};

  // ---- slave FSM ----
  qbus_state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             tmo_hit, settle_done;

  assign tmo_hit     = (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign settle_done = (cnt_reg == CNT_W'(SETTLE - 1));

  always_comb begin
    state_next = state_reg;
    if (rinit_s || !rsync_s) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:      if (hit) state_next = ST_WAIT_DIR;
        ST_WAIT_DIR:  if (rdin_s) state_next = ST_RD_REQ;
                      else if (rdout_s) state_next = ST_WR_REQ;
        ST_RD_REQ:    if (reg_ack) state_next = ST_RD_DRIVE;
                      else if (tmo_hit) state_next = ST_WAIT_SYNC;
        ST_RD_DRIVE:  if (settle_done) state_next = ST_RD_REPLY;
        // Back to WAIT_DIR so the DATO half of a DATIO can follow.
        ST_RD_REPLY:  if (!rdin_s) state_next = ST_WAIT_DIR;
        ST_WR_REQ:    if (reg_ack) state_next = ST_WR_REPLY;
                      else if (tmo_hit) state_next = ST_WAIT_SYNC;
        ST_WR_REPLY:  if (!rdout_s) state_next = ST_WAIT_SYNC;
        ST_WAIT_SYNC: state_next = ST_WAIT_SYNC;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Cycle counter restarts on every state change; it times both the
  // request timeout and the DAL settle window.
  assign cnt_next = (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);

  // ---- registered outputs, decoded from the next state ----
  logic [DAL_W-1:0]  dal_out_reg, dal_out_next;
  logic              daltx_reg, dalst_reg, dalbe_l_reg, trply_reg;
  logic              rd_reg, wr_reg;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [1:0]        be_reg, be_next;
  logic              driving_next;

  always_comb begin
    driving_next = (state_next == ST_RD_DRIVE) || (state_next == ST_RD_REPLY);
    dal_out_next = '0;
    if (driving_next)
      dal_out_next = (state_reg == ST_RD_REQ) ? {{(DAL_W-DATA_W){1'b0}}, reg_rdata}
                                              : dal_out_reg;
    be_next = 2'b00;
    if (state_next == ST_RD_REQ)
      be_next = 2'b11;
    else if (state_next == ST_WR_REQ)
      be_next = (state_reg == ST_WAIT_DIR) ? write_be(zwtbt_reg, addr_reg[0]) : be_reg;
    wdata_next = wdata_reg;
    if (state_reg == ST_WAIT_DIR && state_next == ST_WR_REQ)
      wdata_next = zdal_reg;
  end

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      dal_out_reg <= '0;
      daltx_reg   <= 1'b0;
      dalst_reg   <= 1'b0;
      dalbe_l_reg <= 1'b1;
      trply_reg   <= 1'b0;
      rd_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      wdata_reg   <= '0;
      be_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dal_out_reg <= dal_out_next;
      daltx_reg   <= driving_next;
      dalst_reg   <= (state_next == ST_RD_REPLY);
      dalbe_l_reg <= (state_next != ST_RD_REPLY);
      trply_reg   <= (state_next == ST_RD_REPLY) || (state_next == ST_WR_REPLY);
      rd_reg      <= (state_next == ST_RD_REQ);
      wr_reg      <= (state_next == ST_WR_REQ);
      wdata_reg   <= wdata_next;
      be_reg      <= be_next;
    end
  end

  assign dal_out   = dal_out_reg;
  assign DALtx     = daltx_reg;
  assign DALst     = dalst_reg;
  assign DALbe_L   = dalbe_l_reg;
  assign TRPLY     = trply_reg;
  assign reg_rd    = rd_reg;
  assign reg_wr    = wr_reg;
  assign reg_wdata = wdata_reg;
  assign reg_be    = be_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_qbus_slave_if.sv
// tb_qbus_slave_if
//   Directed plus randomised QBUS slave cycles against qbus_slave_if.
//   The bench plays both bus master and register block; a small word
//   memory models the register contents.
module tb_qbus_slave_if;

  localparam logic [12:0] BASE    = 13'o17570;
  localparam int          SETTLE  = 1;
  localparam int          TIMEOUT = 200;
  localparam int P_RD = 0, P_WR = 1, P_TRPLY = 2;

  logic        clk20 = 1'b0;
  logic        reset;
  logic        RSYNC, RDIN, RDOUT, RINIT;
  logic [21:0] ZDAL;
  logic        ZBS7, ZWTBT;
  logic [21:0] dal_out;
  logic        DALtx, DALst, DALbe_L, TRPLY;
  logic        reg_rd, reg_wr;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [1:0]  reg_be;
  logic [15:0] reg_rdata;
  logic        reg_ack;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] mem [4];

  qbus_slave_if #(
    .BASE_ADDR (BASE),
    .REG_BITS  (2),
    .SETTLE    (SETTLE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk20     (clk20),
    .reset     (reset),
    .RSYNC     (RSYNC),
    .RDIN      (RDIN),
    .RDOUT     (RDOUT),
    .RINIT     (RINIT),
    .ZDAL      (ZDAL),
    .ZBS7      (ZBS7),
    .ZWTBT     (ZWTBT),
    .dal_out   (dal_out),
    .DALtx     (DALtx),
    .DALst     (DALst),
    .DALbe_L   (DALbe_L),
    .TRPLY     (TRPLY),
    .reg_rd    (reg_rd),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .busy      (busy)
  );

  always #25 clk20 = ~clk20;

  // ---- reference model: address decode and byte lanes from the bus rules ----
  function automatic bit model_hit(input logic [12:0] a, input logic bs7);
    return bs7 && ((a / 13'd8) == (BASE / 13'd8));
  endfunction

  function automatic int model_idx(input logic [12:0] a);
    return int'(a / 13'd2) % 4;
  endfunction

  function automatic logic [1:0] model_be(input bit byte_op, input logic [12:0] a);
    if (!byte_op) return 2'b11;
    return (a % 13'd2 == 13'd1) ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk20);
    #1;
  endtask

  function automatic logic probe(input int which);
    case (which)
      P_RD:    return reg_rd;
      P_WR:    return reg_wr;
      default: return TRPLY;
    endcase
  endfunction

  // Ticks until the probed output reaches val; n = ticks taken, -1 on expiry.
  task automatic wait_until(input int which, input logic val, input int maxn, output int n);
    n = 0;
    while (probe(which) !== val && n < maxn) begin
      tick();
      n++;
    end
    if (probe(which) !== val) n = -1;
  endtask

  task automatic start_cycle(input logic [12:0] a, input logic bs7, input logic wtbt);
    ZDAL  = {9'h1ff, a};
    ZBS7  = bs7;
    ZWTBT = wtbt;
    tick();
    RSYNC = 1'b1;
    tick();
    tick();
    ZDAL  = 22'($urandom);
    ZBS7  = 1'($urandom);
    ZWTBT = 1'b0;
    tick();
  endtask

  task automatic end_cycle();
    RSYNC = 1'b0;
    repeat (4) tick();
    check("end_busy", busy, 1'b0);
  endtask

  task automatic do_read(input bit hit, input int idx, input int dly);
    int n;
    logic [15:0] exp_data;
    exp_data = mem[idx];
    ZWTBT = 1'b0;
    RDIN  = 1'b1;
    wait_until(P_RD, 1'b1, 8, n);
    if (hit) begin
      check("rd_latency", n, 3);
      check("rd_addr", reg_addr, idx);
      check("rd_be", reg_be, 2'b11);
      repeat (dly) tick();
      check("rd_hold", reg_rd, 1'b1);
      reg_ack   = 1'b1;
      reg_rdata = exp_data;
      tick();
      reg_ack   = 1'b0;
      reg_rdata = 16'($urandom);
      check("rd_settle_no_trply", TRPLY, 1'b0);
      check("rd_daltx", DALtx, 1'b1);
      check("rd_dal_out", dal_out, {6'b0, exp_data});
      wait_until(P_TRPLY, 1'b1, 8, n);
      check("rd_trply_after_ack", n + 1, 1 + SETTLE);
      check("rd_dalst", DALst, 1'b1);
      check("rd_dalbe_l", DALbe_L, 1'b0);
      check("rd_dal_out_reply", dal_out, {6'b0, exp_data});
      repeat (2) tick();
      RDIN = 1'b0;
      wait_until(P_TRPLY, 1'b0, 8, n);
      check("rd_trply_release", n, 3);
      check("rd_daltx_release", DALtx, 1'b0);
      check("rd_dalbe_release", DALbe_L, 1'b1);
      check("rd_dal_out_release", dal_out, 22'd0);
    end else begin
      check("miss_no_rd", n, -1);
      check("miss_trply", TRPLY, 1'b0);
      check("miss_daltx", DALtx, 1'b0);
      check("miss_busy", busy, 1'b0);
      RDIN = 1'b0;
      tick();
    end
  endtask

  task automatic do_write(input bit hit, input int idx, input logic [12:0] a,
                          input bit byte_op, input logic [15:0] wd, input int dly);
    int n;
    logic [1:0] be;
    be    = model_be(byte_op, a);
    ZDAL  = {6'($urandom), wd};
    ZWTBT = byte_op;
    tick();
    RDOUT = 1'b1;
    wait_until(P_WR, 1'b1, 8, n);
    if (hit) begin
      check("wr_latency", n, 3);
      check("wr_addr", reg_addr, idx);
      check("wr_be", reg_be, be);
      check("wr_wdata", reg_wdata, wd);
      repeat (dly) tick();
      check("wr_hold", reg_wr, 1'b1);
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      check("wr_trply_after_ack", TRPLY, 1'b1);
      check("wr_req_dropped", reg_wr, 1'b0);
      check("wr_no_daltx", DALtx, 1'b0);
      if (be[1]) mem[idx][15:8] = wd[15:8];
      if (be[0]) mem[idx][7:0]  = wd[7:0];
      tick();
      RDOUT = 1'b0;
      wait_until(P_TRPLY, 1'b0, 8, n);
      check("wr_trply_release", n, 3);
    end else begin
      check("miss_no_wr", n, -1);
      check("miss_wr_trply", TRPLY, 1'b0);
      check("miss_wr_daltx", DALtx, 1'b0);
      RDOUT = 1'b0;
      tick();
    end
    ZWTBT = 1'b0;
  endtask

  // op: 0 DATI, 1 DATO, 2 DATOB, 3 DATIO
  task automatic run_txn(input int num, input int op, input logic [12:0] a,
                         input logic bs7, input logic [15:0] wd, input int dly);
    bit hit;
    int idx;
    hit = model_hit(a, bs7);
    idx = model_idx(a);
    $display("txn %0d: op=%0d addr=%o bs7=%0d hit=%0d ack_dly=%0d wdata=%o",
             num, op, a, bs7, hit, dly, wd);
    start_cycle(a, bs7, (op == 1 || op == 2));
    case (op)
      0:       do_read(hit, idx, dly);
      1:       do_write(hit, idx, a, 1'b0, wd, dly);
      2:       do_write(hit, idx, a, 1'b1, wd, dly);
      default: begin
        do_read(hit, idx, dly);
        do_write(hit, idx, a, 1'b0, wd, dly);
      end
    endcase
    end_cycle();
  endtask

  initial begin : watchdog
    #(50 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    bit saw_trply;
    logic [12:0] a;
    reset = 1'b1;
    RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; RINIT = 1'b0;
    ZDAL = '0; ZBS7 = 1'b0; ZWTBT = 1'b0;
    reg_rdata = '0; reg_ack = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
    mem[0] = 16'o123456;
    repeat (2) tick();

    // reset state
    check("rst_dal_out", dal_out, 22'd0);
    check("rst_daltx", DALtx, 1'b0);
    check("rst_dalst", DALst, 1'b0);
    check("rst_dalbe_l", DALbe_L, 1'b1);
    check("rst_trply", TRPLY, 1'b0);
    check("rst_reg_rd", reg_rd, 1'b0);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_wdata", reg_wdata, 16'd0);
    check("rst_be", reg_be, 2'b00);
    check("rst_addr", reg_addr, 2'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (2) tick();

    // directed cycles
    run_txn(0, 0, 13'o17570, 1'b1, 16'o0, 2);         // DATI word 0
    run_txn(1, 1, 13'o17572, 1'b1, 16'o000777, 1);    // DATO word 1
    run_txn(2, 2, 13'o17573, 1'b1, 16'o052400, 0);    // DATOB odd byte
    run_txn(3, 2, 13'o17574, 1'b1, 16'o000123, 3);    // DATOB even byte
    run_txn(4, 0, 13'o17600, 1'b1, 16'o0, 1);         // outside window
    run_txn(5, 1, 13'o17570, 1'b0, 16'o111111, 1);    // BS7 low
    run_txn(6, 3, 13'o17576, 1'b1, 16'o070707, 2);    // DATIO
    run_txn(7, 0, 13'o17572, 1'b1, 16'o0, 0);         // read back write
    run_txn(8, 0, 13'o17573, 1'b1, 16'o0, 0);         // read back byte

    // randomised cycles
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) != 0) a = BASE + 13'($urandom_range(0, 7));
      else a = 13'($urandom);
      run_txn(100 + t, int'($urandom_range(0, 3)), a,
              1'($urandom_range(0, 4) != 0), 16'($urandom), int'($urandom_range(0, 4)));
    end

    // timeout: no ack, request held TIMEOUT cycles then dropped without reply
    $display("txn 200: timeout read at %o", BASE);
    start_cycle(BASE, 1'b1, 1'b0);
    RDIN = 1'b1;
    wait_until(P_RD, 1'b1, 8, n);
    check("tmo_rd_latency", n, 3);
    n = 0;
    saw_trply = 1'b0;
    while (reg_rd === 1'b1 && n < TIMEOUT + 20) begin
      tick();
      n++;
      if (TRPLY) saw_trply = 1'b1;
    end
    check("tmo_hold_cycles", n, TIMEOUT);
    reg_ack = 1'b1;    // late ack with nothing pending
    tick();
    reg_ack = 1'b0;
    repeat (3) tick();
    check("tmo_no_trply_seen", saw_trply, 1'b0);
    check("tmo_trply", TRPLY, 1'b0);
    check("tmo_daltx", DALtx, 1'b0);
    check("tmo_reg_rd", reg_rd, 1'b0);
    check("tmo_busy_wait_sync", busy, 1'b1);
    RDIN = 1'b0;
    end_cycle();

    // RINIT during the reply phase of a read
    $display("txn 201: RINIT during read at %o", BASE + 13'd2);
    start_cycle(BASE + 13'd2, 1'b1, 1'b0);
    RDIN = 1'b1;
    wait_until(P_RD, 1'b1, 8, n);
    check("init_rd_latency", n, 3);
    reg_ack = 1'b1;
    reg_rdata = 16'o177777;
    tick();
    reg_ack = 1'b0;
    wait_until(P_TRPLY, 1'b1, 8, n);
    check("init_trply_up", TRPLY, 1'b1);
    RINIT = 1'b1;
    repeat (3) tick();
    check("init_dal_out", dal_out, 22'd0);
    check("init_daltx", DALtx, 1'b0);
    check("init_dalst", DALst, 1'b0);
    check("init_dalbe_l", DALbe_L, 1'b1);
    check("init_trply", TRPLY, 1'b0);
    check("init_reg_rd", reg_rd, 1'b0);
    check("init_reg_wr", reg_wr, 1'b0);
    check("init_be", reg_be, 2'b00);
    check("init_busy", busy, 1'b0);
    RINIT = 1'b0;
    RDIN  = 1'b0;
    end_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
